// File: rtl/qpu_exu_dispq_pkg.sv
// Shared defaults for the QPU execute-unit dispatch queue.
// The top-level parameters default to these values.
package qpu_exu_dispq_pkg;

    localparam int QPU_DECINFO_WIDTH = 32;
    localparam int QPU_PC_SIZE       = 32;
    localparam int QPU_TIME_WIDTH    = 16;
    localparam int QPU_QUBIT_NUM     = 8;
    localparam int QPU_RFIDX_W       = 5;
    localparam int QPU_NCH           = 2;

    // Index width that stays at least one bit when only one value is needed.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [idx_w(QPU_NCH)-1:0] qpu_ch_t;

endpackage

// File: rtl/qpu_exu_dispq_fifo.sv
// Dispatch-queue storage: entry flops, wrap-around pointers with an extra MSB
// for full/empty, and a per-slot occupancy view for hazard scanning.
module qpu_exu_dispq_fifo
    import qpu_exu_dispq_pkg::*;
#(
    parameter int DW     = 8,
    parameter int QDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DW-1:0]               wr_data,
    input  logic                        rd_en,
    input  logic                        flush,
    output logic [DW-1:0]               rd_data,
    output logic [QDEPTH-1:0][DW-1:0]   ent,
    output logic [QDEPTH-1:0]           ent_vld,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = idx_w(QDEPTH);

    logic [QDEPTH-1:0][DW-1:0] mem;
    logic [AW:0]               wptr;
    logic [AW:0]               rptr;
    logic [AW:0]               cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // Payload needs no reset; occupancy comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
    end

    assign cnt     = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = mem[rptr[AW-1:0]];
    assign ent     = mem;

    always_comb begin
        logic [AW-1:0] off;
        off     = '0;
        ent_vld = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            off        = AW'(i) - rptr[AW-1:0];
            ent_vld[i] = ({1'b0, off} < cnt);
        end
    end

endmodule

// File: rtl/qpu_exu_dispq.sv
// QPU execute-unit dispatch queue: in-order queue between decode and the
// functional-unit channels, with register hazard blocking and measure credits.
module qpu_exu_dispq
    import qpu_exu_dispq_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int QDEPTH    = 4,
    parameter int MCREDIT   = 4,
    parameter int XLEN      = 32,
    parameter int RFIDX_W   = QPU_RFIDX_W,
    parameter int INFO_W    = QPU_DECINFO_WIDTH,
    parameter int PC_W      = QPU_PC_SIZE,
    parameter int TIME_W    = QPU_TIME_WIDTH,
    parameter int QUBIT_NUM = QPU_QUBIT_NUM,
    localparam int CHW      = idx_w(NCH),
    localparam int MCW      = $clog2(MCREDIT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 disp_i_valid,
    output logic                 disp_i_ready,
    input  logic [CHW-1:0]       disp_i_ch,
    input  logic                 disp_i_longp,
    input  logic [XLEN-1:0]      disp_i_rs1,
    input  logic [XLEN-1:0]      disp_i_rs2,
    input  logic                 disp_i_rs1x0,
    input  logic                 disp_i_rs2x0,
    input  logic                 disp_i_rs1en,
    input  logic                 disp_i_rs2en,
    input  logic [RFIDX_W-1:0]   disp_i_rs1idx,
    input  logic [RFIDX_W-1:0]   disp_i_rs2idx,
    input  logic [RFIDX_W-1:0]   disp_i_rdidx,
    input  logic                 disp_i_rdwen,
    input  logic [INFO_W-1:0]    disp_i_info,
    input  logic [XLEN-1:0]      disp_i_imm,
    input  logic [PC_W-1:0]      disp_i_pc,
    input  logic [TIME_W-1:0]    disp_i_clk,
    input  logic [QUBIT_NUM-1:0] disp_i_qmr,
    input  logic                 disp_i_ntp,
    input  logic                 disp_i_measure,
    input  logic                 disp_i_fmr,
    input  logic                 oitf_dep,
    input  logic                 oitf_ready,
    input  logic                 meas_ret,
    input  logic                 flush,
    output logic [NCH-1:0]       disp_o_valid,
    input  logic [NCH-1:0]       disp_o_ready,
    output logic [XLEN-1:0]      disp_o_rs1,
    output logic [XLEN-1:0]      disp_o_rs2,
    output logic                 disp_o_rdwen,
    output logic [RFIDX_W-1:0]   disp_o_rdidx,
    output logic [INFO_W-1:0]    disp_o_info,
    output logic [XLEN-1:0]      disp_o_imm,
    output logic [PC_W-1:0]      disp_o_pc,
    output logic [TIME_W-1:0]    disp_o_clk,
    output logic [QUBIT_NUM-1:0] disp_o_qmr,
    output logic                 disp_o_ntp,
    output logic                 disp_o_measure,
    output logic                 disp_o_fmr,
    output logic                 disp_oitf_ena,
    output logic                 disp_moitf_ena,
    output logic [MCW-1:0]       mcredit
);

    typedef struct packed {
        logic [CHW-1:0]       ch;
        logic                 longp;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic                 rdwen;
        logic [RFIDX_W-1:0]   rdidx;
        logic [INFO_W-1:0]    info;
        logic [XLEN-1:0]      imm;
        logic [PC_W-1:0]      pc;
        logic [TIME_W-1:0]    tclk;
        logic [QUBIT_NUM-1:0] qmr;
        logic                 ntp;
        logic                 measure;
        logic                 fmr;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t                wr_ent;
    entry_t                head;
    entry_t [QDEPTH-1:0]   qent;
    logic   [QDEPTH-1:0]   qvld;
    logic                  full;
    logic                  empty;
    logic                  qdep;
    logic                  head_ok;
    logic                  enq;
    logic                  deq;

    qpu_exu_dispq_fifo #(
        .DW     (EW),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (enq),
        .wr_data (wr_ent),
        .rd_en   (deq),
        .flush   (flush),
        .rd_data (head),
        .ent     (qent),
        .ent_vld (qvld),
        .full    (full),
        .empty   (empty)
    );

    // Operand/field canonicalisation happens on the way in, not at dispatch.
    always_comb begin
        wr_ent         = '0;
        wr_ent.ch      = disp_i_ch;
        wr_ent.longp   = disp_i_longp;
        wr_ent.rs1     = disp_i_rs1x0 ? '0 : disp_i_rs1;
        wr_ent.rs2     = disp_i_rs2x0 ? '0 : disp_i_rs2;
        wr_ent.rdwen   = disp_i_rdwen;
        wr_ent.rdidx   = disp_i_rdidx;
        wr_ent.info    = disp_i_info;
        wr_ent.imm     = disp_i_imm;
        wr_ent.pc      = disp_i_pc;
        wr_ent.tclk    = disp_i_ntp ? disp_i_clk : '0;
        wr_ent.qmr     = disp_i_fmr ? disp_i_qmr : '0;
        wr_ent.ntp     = disp_i_ntp;
        wr_ent.measure = disp_i_measure;
        wr_ent.fmr     = disp_i_fmr;
    end

    always_comb begin
        qdep = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (qvld[i] && qent[i].rdwen &&
                ((disp_i_rs1en && qent[i].rdidx == disp_i_rs1idx) ||
                 (disp_i_rs2en && qent[i].rdidx == disp_i_rs2idx) ||
                 (disp_i_rdwen && qent[i].rdidx == disp_i_rdidx)))
                qdep = 1'b1;
        end
    end

    // Full blocks enqueue even when the head leaves this cycle.
    assign disp_i_ready = rst_n & ~full & ~oitf_dep & ~qdep & ~flush;
    assign enq          = disp_i_valid & disp_i_ready;

    assign head_ok = ~empty & (~head.longp | oitf_ready) & (~head.measure | (mcredit != '0));

    always_comb begin
        disp_o_valid = '0;
        if (head_ok) disp_o_valid[head.ch] = 1'b1;
    end

    assign deq            = head_ok & disp_o_ready[head.ch] & ~flush;
    assign disp_oitf_ena  = deq & head.longp;
    assign disp_moitf_ena = deq & head.measure;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcredit <= MCW'(MCREDIT);
        end else begin
            case ({disp_moitf_ena, meas_ret})
                2'b10:   mcredit <= mcredit - 1'b1;
                2'b01:   if (mcredit != MCW'(MCREDIT)) mcredit <= mcredit + 1'b1;
                default: mcredit <= mcredit;
            endcase
        end
    end

    assign disp_o_rs1     = head.rs1;
    assign disp_o_rs2     = head.rs2;
    assign disp_o_rdwen   = head.rdwen;
    assign disp_o_rdidx   = head.rdidx;
    assign disp_o_info    = head.info;
    assign disp_o_imm     = head.imm;
    assign disp_o_pc      = head.pc;
    assign disp_o_clk     = head.tclk;
    assign disp_o_qmr     = head.qmr;
    assign disp_o_ntp     = head.ntp;
    assign disp_o_measure = head.measure;
    assign disp_o_fmr     = head.fmr;

endmodule

// File: tb/tb_qpu_exu_dispq.sv
// Directed bench for qpu_exu_dispq (NCH=2, QDEPTH=4, MCREDIT=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_qpu_exu_dispq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_i_valid, disp_i_ready;
    logic [0:0]  disp_i_ch;
    logic        disp_i_longp;
    logic [31:0] disp_i_rs1, disp_i_rs2;
    logic        disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en;
    logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
    logic        disp_i_rdwen;
    logic [31:0] disp_i_info, disp_i_imm, disp_i_pc;
    logic [15:0] disp_i_clk;
    logic [7:0]  disp_i_qmr;
    logic        disp_i_ntp, disp_i_measure, disp_i_fmr;
    logic        oitf_dep, oitf_ready, meas_ret, flush;
    logic [1:0]  disp_o_valid, disp_o_ready;
    logic [31:0] disp_o_rs1, disp_o_rs2, disp_o_info, disp_o_imm, disp_o_pc;
    logic        disp_o_rdwen;
    logic [4:0]  disp_o_rdidx;
    logic [15:0] disp_o_clk;
    logic [7:0]  disp_o_qmr;
    logic        disp_o_ntp, disp_o_measure, disp_o_fmr;
    logic        disp_oitf_ena, disp_moitf_ena;
    logic [2:0]  mcredit;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    qpu_exu_dispq dut (
        .clk(clk), .rst_n(rst_n),
        .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready),
        .disp_i_ch(disp_i_ch), .disp_i_longp(disp_i_longp),
        .disp_i_rs1(disp_i_rs1), .disp_i_rs2(disp_i_rs2),
        .disp_i_rs1x0(disp_i_rs1x0), .disp_i_rs2x0(disp_i_rs2x0),
        .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
        .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
        .disp_i_rdidx(disp_i_rdidx), .disp_i_rdwen(disp_i_rdwen),
        .disp_i_info(disp_i_info), .disp_i_imm(disp_i_imm), .disp_i_pc(disp_i_pc),
        .disp_i_clk(disp_i_clk), .disp_i_qmr(disp_i_qmr),
        .disp_i_ntp(disp_i_ntp), .disp_i_measure(disp_i_measure), .disp_i_fmr(disp_i_fmr),
        .oitf_dep(oitf_dep), .oitf_ready(oitf_ready), .meas_ret(meas_ret), .flush(flush),
        .disp_o_valid(disp_o_valid), .disp_o_ready(disp_o_ready),
        .disp_o_rs1(disp_o_rs1), .disp_o_rs2(disp_o_rs2),
        .disp_o_rdwen(disp_o_rdwen), .disp_o_rdidx(disp_o_rdidx),
        .disp_o_info(disp_o_info), .disp_o_imm(disp_o_imm), .disp_o_pc(disp_o_pc),
        .disp_o_clk(disp_o_clk), .disp_o_qmr(disp_o_qmr),
        .disp_o_ntp(disp_o_ntp), .disp_o_measure(disp_o_measure), .disp_o_fmr(disp_o_fmr),
        .disp_oitf_ena(disp_oitf_ena), .disp_moitf_ena(disp_moitf_ena), .mcredit(mcredit)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clr_in();
        disp_i_valid = 0; disp_i_ch = 0; disp_i_longp = 0;
        disp_i_rs1 = 0; disp_i_rs2 = 0; disp_i_rs1x0 = 0; disp_i_rs2x0 = 0;
        disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs1idx = 0; disp_i_rs2idx = 0;
        disp_i_rdidx = 0; disp_i_rdwen = 0; disp_i_info = 0; disp_i_imm = 0; disp_i_pc = 0;
        disp_i_clk = 0; disp_i_qmr = 0; disp_i_ntp = 0; disp_i_measure = 0; disp_i_fmr = 0;
    endtask

    task automatic op(input logic [0:0] ch, input logic longp, input logic meas,
                      input logic rdwen, input logic [4:0] rdidx, input logic [31:0] pc);
        clr_in();
        disp_i_valid = 1; disp_i_ch = ch; disp_i_longp = longp; disp_i_measure = meas;
        disp_i_rdwen = rdwen; disp_i_rdidx = rdidx; disp_i_pc = pc;
    endtask

    // Advance one clock: registers update, then land on the next falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clr_in();
        rst_n = 0; oitf_dep = 0; oitf_ready = 0; meas_ret = 0; flush = 0; disp_o_ready = 0;

        // reset state
        @(negedge clk); #1;
        chk("rst_ready", disp_i_ready, 0);
        chk("rst_valid", disp_o_valid, 0);
        chk("rst_mcredit", mcredit, 4);
        chk("rst_ena", {disp_oitf_ena, disp_moitf_ena}, 0);
        @(negedge clk); rst_n = 1; #1;
        chk("rst_rel_ready", disp_i_ready, 1);

        // back-to-back independent ops, ch0 always ready
        disp_o_ready = 2'b01;
        op(0, 0, 0, 0, 0, 32'd10); #1;
        chk("b2b_nobypass", disp_o_valid, 0);
        for (int i = 1; i < 4; i++) begin
            cyc(); op(0, 0, 0, 0, 0, 32'd10 + i); #1;
            chk("b2b_valid", disp_o_valid, 2'b01);
            chk("b2b_pc", disp_o_pc, 32'd10 + i - 1);
            chk("b2b_ready", disp_i_ready, 1);
        end
        cyc(); clr_in(); #1;
        chk("b2b_last_pc", disp_o_pc, 32'd13);
        cyc(); #1;
        chk("b2b_drained", disp_o_valid, 0);

        // fill to full, ready must drop and stay low despite a dequeue
        disp_o_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            op(0, 0, 0, 0, 0, 32'd20 + i); #1;
            chk("fill_ready", disp_i_ready, 1);
            cyc();
        end
        op(0, 0, 0, 0, 0, 32'd99); disp_o_ready = 2'b01; #1;
        chk("full_ready", disp_i_ready, 0);
        chk("full_head", disp_o_pc, 32'd20);
        for (int j = 1; j < 4; j++) begin
            cyc(); clr_in(); #1;
            chk("full_order", disp_o_pc, 32'd20 + j);
        end
        cyc(); #1;
        chk("full_no_extra", disp_o_valid, 0);

        // enqueue-time canonicalisation of operands, qmr and clk
        disp_o_ready = 2'b00;
        op(0, 0, 0, 0, 0, 32'd30);
        disp_i_rs1 = 32'hdead; disp_i_rs1x0 = 1; disp_i_rs2 = 32'h1234;
        disp_i_qmr = 8'hff; disp_i_clk = 16'h55;
        cyc();
        op(0, 0, 0, 0, 0, 32'd31);
        disp_i_rs1 = 32'hdead; disp_i_rs2 = 32'h1234; disp_i_rs2x0 = 1;
        disp_i_qmr = 8'hff; disp_i_fmr = 1; disp_i_clk = 16'h55; disp_i_ntp = 1;
        cyc(); clr_in(); #1;
        chk("zero_rs1", disp_o_rs1, 0);
        chk("keep_rs2", disp_o_rs2, 32'h1234);
        chk("zero_qmr", disp_o_qmr, 0);
        chk("zero_clk", disp_o_clk, 0);
        disp_o_ready = 2'b01;
        cyc(); #1;
        chk("keep_rs1", disp_o_rs1, 32'hdead);
        chk("zero_rs2", disp_o_rs2, 0);
        chk("keep_qmr", disp_o_qmr, 8'hff);
        chk("keep_clk", disp_o_clk, 16'h55);
        cyc(); #1;
        chk("zero_drained", disp_o_valid, 0);

        // register hazard against a queued writer of x5
        disp_o_ready = 2'b00;
        op(1, 0, 0, 1, 5'd5, 32'd40);
        cyc(); clr_in(); disp_i_rs1idx = 5; disp_i_rs1en = 1; #1;
        chk("haz_rs1", disp_i_ready, 0);
        disp_i_rs1en = 0; #1;
        chk("haz_rs1_off", disp_i_ready, 1);
        disp_i_rs2idx = 5; disp_i_rs2en = 1; #1;
        chk("haz_rs2", disp_i_ready, 0);
        disp_i_rs2en = 0; disp_i_rdidx = 5; disp_i_rdwen = 1; #1;
        chk("haz_rd", disp_i_ready, 0);
        disp_i_rdidx = 6; #1;
        chk("haz_rd_other", disp_i_ready, 1);
        oitf_dep = 1; #1;
        chk("haz_oitf_dep", disp_i_ready, 0);
        oitf_dep = 0; clr_in(); disp_i_rs1idx = 5; disp_i_rs1en = 1; disp_o_ready = 2'b10; #1;
        chk("haz_deq_cycle", disp_i_ready, 0);
        chk("haz_deq_valid", disp_o_valid, 2'b10);
        cyc(); #1;
        chk("haz_cleared", disp_i_ready, 1);
        clr_in();

        // long-pipe op waits for OITF space
        disp_o_ready = 2'b11; oitf_ready = 0;
        op(1, 1, 0, 0, 0, 32'd50);
        cyc(); clr_in(); #1;
        chk("longp_hold", disp_o_valid, 0);
        chk("longp_hold_ena", disp_oitf_ena, 0);
        oitf_ready = 1; #1;
        chk("longp_go", disp_o_valid, 2'b10);
        chk("longp_ena", disp_oitf_ena, 1);
        cyc(); #1;
        chk("longp_done", disp_o_valid, 0);

        // five measures against four credits
        disp_o_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            op(0, 0, 1, 0, 0, 32'd80 + i);
            cyc();
        end
        clr_in(); #1;
        chk("meas_credit0", mcredit, 0);
        chk("meas_held", disp_o_valid, 0);
        chk("meas_held_ena", disp_moitf_ena, 0);
        meas_ret = 1;
        cyc(); #1;
        chk("meas_ret_credit", mcredit, 1);
        chk("meas_fifth_go", disp_o_valid, 2'b01);
        chk("meas_fifth_pc", disp_o_pc, 32'd84);
        chk("meas_moitf_ena", disp_moitf_ena, 1);
        cyc(); #1;
        chk("meas_both_same", mcredit, 1);
        for (int i = 0; i < 4; i++) cyc();
        meas_ret = 0; #1;
        chk("meas_saturate", mcredit, 4);

        // flush on a full queue: no dequeue, empty next cycle, credits kept
        disp_o_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            op(0, 0, 1, 0, 0, 32'd60 + i);
            cyc();
        end
        clr_in(); flush = 1; disp_o_ready = 2'b01; #1;
        chk("flush_ready", disp_i_ready, 0);
        chk("flush_no_deq", disp_moitf_ena, 0);
        cyc(); flush = 0; #1;
        chk("flush_empty", disp_o_valid, 0);
        chk("flush_mcredit", mcredit, 4);
        chk("flush_ready_after", disp_i_ready, 1);

        // reset in the middle of traffic
        disp_o_ready = 2'b00;
        op(0, 0, 1, 0, 0, 32'd70);
        cyc(); op(0, 0, 0, 0, 0, 32'd71);
        cyc(); clr_in(); disp_o_ready = 2'b01; #1;
        chk("mid_moitf", disp_moitf_ena, 1);
        cyc(); disp_o_ready = 2'b00; #1;
        chk("mid_credit3", mcredit, 3);
        chk("mid_head", disp_o_pc, 32'd71);
        rst_n = 0; #1;
        chk("mid_rst_credit", mcredit, 4);
        chk("mid_rst_valid", disp_o_valid, 0);
        chk("mid_rst_ready", disp_i_ready, 0);
        cyc(); rst_n = 1; disp_o_ready = 2'b01; #1;
        chk("mid_rst_empty", disp_o_valid, 0);
        chk("mid_rst_ready_rel", disp_i_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qpu_exu_dispq.md
QPU_EXU_DISPQ -- requirements
Module: QPU_exu_dispq

Interface
REQ-001 SHALL have parameter NCH, default 2: number of functional-unit output channels (≥2).
REQ-002 SHALL have parameter QDEPTH, default 4: dispatch-queue entries, power of two, ≥2.
REQ-003 SHALL have parameter MCREDIT, default 4: measure-result FIFO credits, ≥1.
REQ-004 SHALL have parameters XLEN/RFIDX_W/INFO_W/PC_W/TIME_W/QUBIT_NUM, defaults 32/5/`QPU_DECINFO_WIDTH/`QPU_PC_SIZE/`QPU_TIME_WIDTH/`QPU_QUBIT_NUM.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-006 clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-007 disp_i_valid in 1, disp_i_ready out 1: decode-side handshake.
REQ-008 disp_i_ch in clog2(NCH): target channel; disp_i_longp in 1: long-pipe op (allocates OITF).
REQ-009 disp_i_rs1/rs2 in XLEN; disp_i_rs1x0/rs2x0 in 1; disp_i_rs1en/rs2en in 1; disp_i_rs1idx/rs2idx/rdidx in RFIDX_W; disp_i_rdwen in 1.
REQ-010 disp_i_info in INFO_W; disp_i_imm in XLEN; disp_i_pc in PC_W; disp_i_clk in TIME_W; disp_i_qmr in QUBIT_NUM; disp_i_ntp/measure/fmr in 1.
REQ-011 oitf_dep in 1: OR of OITF rs1/rs2/rd/qubit-flag matches for the incoming instruction; oitf_ready in 1.
REQ-012 meas_ret in 1: one-cycle pulse, one measure result drained.
REQ-013 flush in 1: synchronous queue clear.
REQ-014 disp_o_valid out NCH, disp_o_ready in NCH: per-channel handshake.
REQ-015 disp_o_* out: rs1, rs2, rdwen, rdidx, info, imm, pc, clk, qmr, ntp, measure, fmr of the head entry, shared by all channels.
REQ-016 disp_oitf_ena out 1, disp_moitf_ena out 1; mcredit out clog2(MCREDIT+1): current credits.

Function
REQ-017 Enqueue SHALL occur when disp_i_valid & disp_i_ready; disp_i_ready = ~full & ~oitf_dep & ~qdep & ~flush.
REQ-018 qdep SHALL be 1 when any valid queued entry with rdwen has rdidx equal to an enabled incoming rs1idx/rs2idx, or to rdidx when disp_i_rdwen.
REQ-019 At enqueue: rs1/rs2 zeroed when rs1x0/rs2x0; qmr zeroed unless fmr; clk zeroed unless ntp.
REQ-020 Latency accept-to-output SHALL be exactly 1 cycle; no combinational bypass.
REQ-021 When full, disp_i_ready SHALL be 0 even if a dequeue occurs that cycle.
REQ-022 disp_o_valid[k] = ~empty & head.ch==k & (~head.longp | oitf_ready) & (~head.measure | mcredit!=0); all other bits 0.
REQ-023 Dequeue SHALL occur when disp_o_valid[head.ch] & disp_o_ready[head.ch]; strict in-order, head only.
REQ-024 disp_oitf_ena = dequeue & head.longp; disp_moitf_ena = dequeue & head.measure.
REQ-025 mcredit: −1 on disp_moitf_ena, +1 on meas_ret, unchanged when both; meas_ret at MCREDIT SHALL saturate.
REQ-026 Pointers SHALL wrap modulo QDEPTH; full/empty via extra pointer MSB.
REQ-027 flush SHALL empty the queue next cycle, suppress dequeue that cycle, leave mcredit unchanged.

Reset
REQ-028 On rst_n low: queue empty, pointers 0, mcredit=MCREDIT, disp_o_valid=0, disp_i_ready=0 during reset, ena outputs 0.
REQ-029 Reset mid-operation SHALL discard all entries; payload registers need no reset.

Structure
REQ-030 Entry field widths and the channel-index typedef SHALL live in QPU_defines.v.
REQ-031 Storage SHALL be one sub-module QPU_exu_dispq_fifo (flops, pointers, full/empty); hazard check and credits in the top.

Verification
REQ-032 Back-to-back 4 independent ALU ops, ch0 ready=1 -> outputs 1 cycle after each accept, order preserved, ready low only when full.
REQ-033 Queued rdidx=5 op, incoming rs1idx=5 rs1en=1 -> disp_i_ready=0 until that entry dequeues.
REQ-034 MCREDIT=4, five measures, no meas_ret -> fifth held (valid=0), meas_ret pulse -> fifth dispatches, mcredit back to 0.
REQ-035 Head longp on ch1, oitf_ready=0 -> disp_o_valid=0; oitf_ready=1 -> valid[1]=1, disp_oitf_ena=1 on handshake.
REQ-036 Full queue, flush=1 with ch ready=1 -> no dequeue, empty next cycle, mcredit unchanged; rst_n low mid-stream -> empty, mcredit=4.
